branch_hazard_sched: RTL

Decode-stage scheduler for the branch comparator. It keeps a shadow scoreboard of in-flight register writes in the E, M and W stages. From that scoreboard it produces the forwarding selects for both comparator operands and the pipeline stall. It qualifies the comparator's taken result into a redirect, and keeps saturating branch and stall performance counters plus a stall watchdog.

---
 rtl/branch_hazard_sched_pkg.sv | 33 +++
 rtl/branch_hazard_sched_hazard_slot_match.sv | 59 +++++
 rtl/branch_hazard_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/branch_hazard_sched_pkg.sv
// Shared decode/forwarding definitions: forwarding-select encodings, scoreboard slot layout
// and the slot ageing helper used by the branch hazard scheduler.
package branch_hazard_sched_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    typedef enum logic [1:0] {
        B_SEL_RF = FWD_RF,
        B_SEL_E  = FWD_E,
        B_SEL_M  = FWD_M,
        B_SEL_W  = FWD_W
    } b_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rnum;
        logic [1:0] tnew;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    // One pipeline step closer to having the result available.
    function automatic slot_t slot_age(input slot_t s);
        slot_t r;
        r      = s;
        r.tnew = (s.tnew == 2'd0) ? 2'd0 : (s.tnew - 2'd1);
        return r;
    endfunction

endpackage

// File: rtl/branch_hazard_sched_hazard_slot_match.sv
// Finds the youngest in-flight writer of one comparator operand and reports
// whether its value is not yet forwardable (hazard) or which stage to forward from.
module hazard_slot_match
    import branch_hazard_sched_pkg::*;
(
    input  logic [4:0]        i_reg,
    input  logic [SLOT_W-1:0] i_slot_e,
    input  logic [SLOT_W-1:0] i_slot_m,
    input  logic [SLOT_W-1:0] i_slot_w,
    output logic              o_hazard,
    output logic [1:0]        o_sel
);

    slot_t  w_e;
    slot_t  w_m;
    slot_t  w_w;
    slot_t  w_hit;
    logic   w_found;
    b_sel_e w_stage;

    assign w_e = slot_t'(i_slot_e);
    assign w_m = slot_t'(i_slot_m);
    assign w_w = slot_t'(i_slot_w);

    always_comb begin
        w_found = 1'b0;
        w_stage = B_SEL_RF;
        w_hit   = '0;
        // $0 never carries a dependency even if a stale slot names it.
        if (i_reg != 5'd0) begin
            if (w_e.valid && (w_e.rnum == i_reg)) begin
                w_found = 1'b1;
                w_stage = B_SEL_E;
                w_hit   = w_e;
            end else if (w_m.valid && (w_m.rnum == i_reg)) begin
                w_found = 1'b1;
                w_stage = B_SEL_M;
                w_hit   = w_m;
            end else if (w_w.valid && (w_w.rnum == i_reg)) begin
                w_found = 1'b1;
                w_stage = B_SEL_W;
                w_hit   = w_w;
            end
        end
    end

    always_comb begin
        o_hazard = 1'b0;
        o_sel    = FWD_RF;
        if (w_found) begin
            if (w_hit.tnew != 2'd0) begin
                o_hazard = 1'b1;
            end else begin
                o_sel = w_stage;
            end
        end
    end

endmodule

// File: rtl/branch_hazard_sched.sv
// Decode-stage branch scheduler: E/M/W write scoreboard, comparator forwarding selects,
// stall/redirect generation, saturating perf counters and a sticky stall watchdog.
module branch_hazard_sched
    import branch_hazard_sched_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic             d_is_branch,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_use_rt,
    input  logic [4:0]       d_wr_reg,
    input  logic [1:0]       d_tnew,
    input  logic             ext_stall,
    input  logic             j_zero,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic             stall,
    output logic             br_taken,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cyc,
    output logic             err_stall
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [7:0]       MAX_STALL_B = 8'(MAX_STALL);

    slot_t            r_slot_e;
    slot_t            r_slot_m;
    slot_t            r_slot_w;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_stall_cyc;
    logic [7:0]       r_run;
    logic             r_err;

    logic             w_haz1;
    logic             w_haz2_raw;
    logic [1:0]       w_sel1;
    logic [1:0]       w_sel2_raw;
    logic             w_haz2;
    logic             w_is_br;
    logic             w_stall;
    logic             w_br_fire;
    logic             w_taken;
    logic [7:0]       w_run_nxt;
    slot_t            w_slot_e_nxt;

    hazard_slot_match u_match_rs (
        .i_reg    (d_rs),
        .i_slot_e (r_slot_e),
        .i_slot_m (r_slot_m),
        .i_slot_w (r_slot_w),
        .o_hazard (w_haz1),
        .o_sel    (w_sel1)
    );

    hazard_slot_match u_match_rt (
        .i_reg    (d_rt),
        .i_slot_e (r_slot_e),
        .i_slot_m (r_slot_m),
        .i_slot_w (r_slot_w),
        .o_hazard (w_haz2_raw),
        .o_sel    (w_sel2_raw)
    );

    assign w_haz2    = d_use_rt & w_haz2_raw;
    assign w_is_br   = d_valid & d_is_branch;
    assign w_stall   = (w_is_br & (w_haz1 | w_haz2)) | ext_stall;
    assign w_br_fire = w_is_br & ~w_stall;
    assign w_taken   = w_br_fire & j_zero;

    assign fwd_sel1  = w_sel1;
    assign fwd_sel2  = d_use_rt ? w_sel2_raw : FWD_RF;
    assign stall     = w_stall;
    assign br_taken  = w_taken;
    assign br_cnt    = r_br_cnt;
    assign taken_cnt = r_taken_cnt;
    assign stall_cyc = r_stall_cyc;
    assign err_stall = r_err;

    always_comb begin
        w_slot_e_nxt = '0;
        if (!w_stall) begin
            w_slot_e_nxt.valid = d_valid && (d_wr_reg != 5'd0);
            w_slot_e_nxt.rnum  = d_wr_reg;
            w_slot_e_nxt.tnew  = d_tnew;
        end
    end

    // Run length saturates so a very long stall cannot wrap below the threshold.
    assign w_run_nxt = !w_stall        ? 8'd0  :
                       (r_run == 8'hFF) ? r_run : (r_run + 8'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot_e <= '0;
            r_slot_m <= '0;
            r_slot_w <= '0;
        end else begin
            r_slot_e <= w_slot_e_nxt;
            r_slot_m <= slot_age(r_slot_e);
            r_slot_w <= slot_age(r_slot_m);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
            r_stall_cyc <= '0;
        end else begin
            if (w_br_fire && (r_br_cnt != CNT_MAX)) begin
                r_br_cnt <= r_br_cnt + CNT_ONE;
            end
            if (w_taken && (r_taken_cnt != CNT_MAX)) begin
                r_taken_cnt <= r_taken_cnt + CNT_ONE;
            end
            if (w_stall && (r_stall_cyc != CNT_MAX)) begin
                r_stall_cyc <= r_stall_cyc + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run <= 8'd0;
            r_err <= 1'b0;
        end else begin
            r_run <= w_run_nxt;
            if (w_run_nxt >= MAX_STALL_B) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
